// File: rtl/lift_car_plant.sv
// Lift car plant model: one car, floor travel timing, door position and an unsafe-command trap.
// Optional door model with open/close timing: define LIFT_PLANT_DOOR_MODEL_EN.
module lift_car_plant #(
  parameter int N_FLOORS      = 12,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8,
  parameter int INIT_FLOOR    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        motion,
  input  logic                        direction,
  input  logic                        door_open,
  output logic [N_FLOORS-1:0]         floor_sense,
  output logic [$clog2(N_FLOORS)-1:0] car_pos,
  output logic                        door_closed,
  output logic                        fault
);

  localparam int PW = $clog2(N_FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam logic [PW-1:0]       TOP_FLOOR    = PW'(N_FLOORS - 1);
  localparam logic [PW-1:0]       BOTTOM_FLOOR = {PW{1'b0}};
  localparam logic [PW-1:0]       INIT_POS     = PW'(INIT_FLOOR);
  localparam logic [TW-1:0]       TRAVEL_LAST  = TW'(TRAVEL_CYCLES - 1);
  localparam logic [N_FLOORS-1:0] ONE_HOT_BASE = {{(N_FLOORS-1){1'b0}}, 1'b1};

  if (N_FLOORS < 2 || TRAVEL_CYCLES < 2 || DOOR_CYCLES < 1 ||
      INIT_FLOOR < 0 || INIT_FLOOR >= N_FLOORS) begin : g_bad_params
    $error("lift_car_plant: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_MOVING  = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t              state_r, state_nxt;
  logic [TW-1:0]       travel_r, travel_nxt;
  logic [PW-1:0]       car_pos_r, pos_nxt;
  logic                dir_r, dir_nxt;
  logic [N_FLOORS-1:0] floor_sense_r, floor_sense_nxt;
  logic                door_closed_r, door_closed_nxt;
  logic                fault_r, fault_nxt;

`ifdef LIFT_PLANT_DOOR_MODEL_EN
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [DW-1:0] DOOR_MAX = DW'(DOOR_CYCLES);
  logic [DW-1:0] door_cnt_r, door_nxt;
`endif

  // Next-state, datapath and registered-output precomputation
  always_comb begin
    state_nxt       = state_r;
    travel_nxt      = travel_r;
    pos_nxt         = car_pos_r;
    dir_nxt         = dir_r;
    door_closed_nxt = door_closed_r;
`ifdef LIFT_PLANT_DOOR_MODEL_EN
    door_nxt        = door_cnt_r;
`endif
    case (state_r)
      ST_STOPPED: begin
        if (motion && !door_open && door_closed_r) begin
          if ((direction && car_pos_r == TOP_FLOOR) ||
              (!direction && car_pos_r == BOTTOM_FLOOR)) begin
            state_nxt = ST_FAULT;
          end else begin
            state_nxt  = ST_MOVING;
            travel_nxt = {TW{1'b0}};
            dir_nxt    = direction;
          end
        end else begin
          state_nxt = ST_STOPPED;
        end
`ifdef LIFT_PLANT_DOOR_MODEL_EN
        if (door_open) begin
          door_nxt = (door_cnt_r == DOOR_MAX) ? DOOR_MAX : door_cnt_r + DW'(1);
        end else begin
          door_nxt = (door_cnt_r == {DW{1'b0}}) ? {DW{1'b0}} : door_cnt_r - DW'(1);
        end
`else
        door_closed_nxt = ~door_open;
`endif
      end
      ST_MOVING: begin
        // Unsafe commands take priority over a coincident arrival.
        if (door_open || (motion && (direction != dir_r))) begin
          state_nxt = ST_FAULT;
        end else if (travel_r == TRAVEL_LAST) begin
          state_nxt  = ST_STOPPED;
          travel_nxt = {TW{1'b0}};
          pos_nxt    = dir_r ? car_pos_r + PW'(1) : car_pos_r - PW'(1);
        end else begin
          travel_nxt = travel_r + TW'(1);
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_FAULT;
      end
    endcase
`ifdef LIFT_PLANT_DOOR_MODEL_EN
    door_closed_nxt = (door_nxt == {DW{1'b0}});
`endif
    floor_sense_nxt = (state_nxt == ST_STOPPED) ? (ONE_HOT_BASE << pos_nxt) : {N_FLOORS{1'b0}};
    fault_nxt       = (state_nxt == ST_FAULT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_STOPPED;
      travel_r      <= {TW{1'b0}};
      car_pos_r     <= INIT_POS;
      dir_r         <= 1'b0;
      floor_sense_r <= ONE_HOT_BASE << INIT_POS;
      door_closed_r <= 1'b1;
      fault_r       <= 1'b0;
`ifdef LIFT_PLANT_DOOR_MODEL_EN
      door_cnt_r    <= {DW{1'b0}};
`endif
    end else begin
      state_r       <= state_nxt;
      travel_r      <= travel_nxt;
      car_pos_r     <= pos_nxt;
      dir_r         <= dir_nxt;
      floor_sense_r <= floor_sense_nxt;
      door_closed_r <= door_closed_nxt;
      fault_r       <= fault_nxt;
`ifdef LIFT_PLANT_DOOR_MODEL_EN
      door_cnt_r    <= door_nxt;
`endif
    end
  end

  assign floor_sense = floor_sense_r;
  assign car_pos     = car_pos_r;
  assign door_closed = door_closed_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_lift_car_plant.sv
// Directed bench for lift_car_plant (4 floors, 5-cycle travel, 3-cycle door).
module tb_lift_car_plant;

  logic       clk = 1'b0;
  logic       reset;
  logic       motion;
  logic       direction;
  logic       door_open;
  logic [3:0] floor_sense;
  logic [1:0] car_pos;
  logic       door_closed;
  logic       fault;

  int errors = 0;
  int checks = 0;

  lift_car_plant #(
    .N_FLOORS(4), .TRAVEL_CYCLES(5), .DOOR_CYCLES(3), .INIT_FLOOR(0)
  ) dut (
    .clk(clk), .reset(reset), .motion(motion), .direction(direction),
    .door_open(door_open), .floor_sense(floor_sense), .car_pos(car_pos),
    .door_closed(door_closed), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    motion = 1'b0;
    direction = 1'b0;
    door_open = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_fs", 32'(floor_sense), 32'h1);
    check("rst_pos", 32'(car_pos), 32'h0);
    check("rst_dc", 32'(door_closed), 32'h1);
    check("rst_fault", 32'(fault), 32'h0);
  endtask

  // One floor leg: 5 cycles with floor_sense clear, then arrival shown.
  task automatic leg(input logic up, input logic hold, input logic [3:0] exp_fs, input logic [1:0] exp_pos);
    motion = 1'b1;
    direction = up;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!hold) motion = 1'b0;
      check("leg_moving_fs", 32'(floor_sense), 32'h0);
    end
    tick();
    check("leg_arrive_fs", 32'(floor_sense), 32'(exp_fs));
    check("leg_arrive_pos", 32'(car_pos), 32'(exp_pos));
    check("leg_fault", 32'(fault), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    motion = 1'b0;
    direction = 1'b0;
    door_open = 1'b0;
    tick();
    do_reset();

    // Single up leg with a one-cycle motion pulse, then down back to 0.
    leg(1'b1, 1'b0, 4'b0010, 2'd1);
    leg(1'b0, 1'b0, 4'b0001, 2'd0);

    // Held motion up to the top floor, then over-travel fault.
    leg(1'b1, 1'b1, 4'b0010, 2'd1);
    leg(1'b1, 1'b1, 4'b0100, 2'd2);
    leg(1'b1, 1'b1, 4'b1000, 2'd3);
    tick();
    check("top_fault", 32'(fault), 32'h1);
    check("top_fault_fs", 32'(floor_sense), 32'h0);
    motion = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_sticky", 32'(fault), 32'h1);
      check("fault_pos", 32'(car_pos), 32'h3);
    end
    do_reset();

    // Door opened in the third moving cycle.
    motion = 1'b1;
    direction = 1'b1;
    tick();
    tick();
    tick();
    door_open = 1'b1;
    tick();
    check("door_mov_fault", 32'(fault), 32'h1);
    check("door_mov_fs", 32'(floor_sense), 32'h0);
    check("door_mov_pos", 32'(car_pos), 32'h0);
    do_reset();

    // Bottom-floor down command.
    motion = 1'b1;
    direction = 1'b0;
    tick();
    check("bottom_fault", 32'(fault), 32'h1);
    do_reset();

    // Reversal while moving.
    motion = 1'b1;
    direction = 1'b1;
    tick();
    tick();
    direction = 1'b0;
    tick();
    check("reverse_fault", 32'(fault), 32'h1);
    do_reset();

`ifdef LIFT_PLANT_DOOR_MODEL_EN
    // Door open 4 cycles, then close while motion is requested.
    door_open = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("door_opening_dc", 32'(door_closed), 32'h0);
    end
    door_open = 1'b0;
    motion = 1'b1;
    direction = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("door_closing_dc", 32'(door_closed), 32'h0);
      check("door_wait_fs", 32'(floor_sense), 32'h1);
      check("door_wait_fault", 32'(fault), 32'h0);
    end
    tick();
    check("door_shut_dc", 32'(door_closed), 32'h1);
    check("door_shut_fs", 32'(floor_sense), 32'h1);
    tick();
    check("depart_fs", 32'(floor_sense), 32'h0);
    check("depart_dc", 32'(door_closed), 32'h1);
`else
    // Motion with door open waits; one-cycle door pulse.
    door_open = 1'b1;
    motion = 1'b1;
    direction = 1'b1;
    tick();
    check("door_pulse_dc", 32'(door_closed), 32'h0);
    check("door_wait_fs", 32'(floor_sense), 32'h1);
    check("door_wait_fault", 32'(fault), 32'h0);
    door_open = 1'b0;
    motion = 1'b0;
    tick();
    check("door_pulse_end", 32'(door_closed), 32'h1);
    tick();
    check("door_pulse_stay", 32'(door_closed), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
